// File: rtl/pedal_sensor_cond_pkg.sv
// Shared constants and types for the pedal sensor conditioning block.
package pedal_pkg;

  typedef logic [11:0] torque_t;
  typedef logic [4:0]  cadence_t;

  localparam cadence_t CAD_SAT       = 5'd31;
  localparam cadence_t PEDAL_MIN_CAD = 5'd2;
  localparam int       AVG_SHIFT     = 4;

  function automatic cadence_t cad_sat_inc(input cadence_t c, input logic inc);
    return (inc && (c != CAD_SAT)) ? c + 5'd1 : c;
  endfunction

endpackage

// File: rtl/pedal_sensor_cond_if.sv
// Torque sample input and conditioned operand outputs of pedal_sensor_cond.
interface pedal_sensor_cond_if;
  import pedal_pkg::*;

  torque_t  torque;
  logic     torque_vld;
  torque_t  avg_torque;
  cadence_t cadence;
  logic     not_pedaling;
  logic     cad_upd;

  modport master (
    output torque, torque_vld,
    input  avg_torque, cadence, not_pedaling, cad_upd
  );

  modport slave (
    input  torque, torque_vld,
    output avg_torque, cadence, not_pedaling, cad_upd
  );

endinterface

// File: rtl/pedal_sensor_cond_cadence_meas.sv
// Cadence measurement: synchronizer, optional glitch filter (CADENCE_FILT_EN),
// edge detect and fixed-window edge counting.
module cadence_meas
  import pedal_pkg::*;
#(
  parameter int CAD_WIN_BITS = 16,
  parameter int FILT_CYC     = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     cadence_in,
  output cadence_t cadence,
  output logic     not_pedaling,
  output logic     cad_upd
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic filt;
  logic filt_dly_q, filt_dly_d;
  logic rise;

  logic [CAD_WIN_BITS-1:0] win_cnt_q, win_cnt_d;
  logic                    term;
  cadence_t                edge_cnt_q, edge_cnt_d;
  cadence_t                cadence_q, cadence_d;
  cadence_t                cad_new;
  logic                    np_q, np_d;
  logic                    upd_q, upd_d;

  assign sync1_d    = cadence_in;
  assign sync2_d    = sync1_q;
  assign filt_dly_d = filt;
  assign rise       = filt & ~filt_dly_q;

`ifdef CADENCE_FILT_EN
  localparam int FW = $clog2(FILT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);

  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_q, filt_lvl_d;

  // The filtered level only follows after FILT_CYC consecutive disagreeing cycles.
  always_comb begin
    filt_cnt_d = '0;
    filt_lvl_d = filt_q;
    if (sync2_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) filt_lvl_d = ~filt_q;
      else                         filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_lvl_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  assign term = &win_cnt_q;

  // An edge landing in the terminal cycle is counted in the closing window.
  always_comb begin
    win_cnt_d  = win_cnt_q + 1'b1;
    cad_new    = cad_sat_inc(edge_cnt_q, rise);
    edge_cnt_d = term ? '0 : cad_new;
    cadence_d  = cadence_q;
    np_d       = np_q;
    upd_d      = 1'b0;
    if (term) begin
      cadence_d = cad_new;
      np_d      = (cad_new < PEDAL_MIN_CAD);
      upd_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_dly_q <= 1'b0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      cadence_q  <= '0;
      np_q       <= 1'b1;
      upd_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_dly_q <= filt_dly_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cadence_q  <= cadence_d;
      np_q       <= np_d;
      upd_q      <= upd_d;
    end
  end

  assign cadence      = cadence_q;
  assign not_pedaling = np_q;
  assign cad_upd      = upd_q;

endmodule

// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning top: cadence measurement plus 1/16 torque averager.
// Define CADENCE_FILT_EN to compile in the cadence glitch filter.
module pedal_sensor_cond
  import pedal_pkg::*;
#(
  parameter int CAD_WIN_BITS = 16,
  parameter int FILT_CYC     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cadence_in,
  pedal_sensor_cond_if.slave  bus
);

  localparam int ACC_W = 12 + AVG_SHIFT;

  logic [ACC_W-1:0] accum_q, accum_d;
  logic             seeded_q, seeded_d;

  cadence_meas #(
    .CAD_WIN_BITS (CAD_WIN_BITS),
    .FILT_CYC     (FILT_CYC)
  ) u_cadence_meas (
    .clk          (clk),
    .rst          (rst),
    .cadence_in   (cadence_in),
    .cadence      (bus.cadence),
    .not_pedaling (bus.not_pedaling),
    .cad_upd      (bus.cad_upd)
  );

  // The first sample seeds the average so it does not ramp up from zero.
  always_comb begin
    accum_d  = accum_q;
    seeded_d = seeded_q;
    if (bus.torque_vld) begin
      seeded_d = 1'b1;
      if (!seeded_q) accum_d = {bus.torque, {AVG_SHIFT{1'b0}}};
      else           accum_d = accum_q - ACC_W'(accum_q[ACC_W-1:AVG_SHIFT]) + ACC_W'(bus.torque);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accum_q  <= '0;
      seeded_q <= 1'b0;
    end else begin
      accum_q  <= accum_d;
      seeded_q <= seeded_d;
    end
  end

  assign bus.avg_torque = accum_q[ACC_W-1:AVG_SHIFT];

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Directed bench for pedal_sensor_cond with a 256-cycle cadence window.
module tb_pedal_sensor_cond;
  import pedal_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cadence_in = 1'b0;

  always #5 clk = ~clk;

  pedal_sensor_cond_if bus();

  pedal_sensor_cond #(.CAD_WIN_BITS(8), .FILT_CYC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cadence_in (cadence_in),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc = 0, rel_cyc = 0;
  int last_upd = -1, first_upd = -1, min_gap = 1000000, n_upd = 0;
  int n0;
  logic [15:0] acc;
  logic [11:0] prev;
  int j;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, log cad_upd timing, then drive cadence_in.
  task automatic step(input logic cin);
    @(negedge clk);
    cyc++;
    if (bus.cad_upd === 1'b1) begin
      if (first_upd < 0) first_upd = cyc - rel_cyc;
      if (last_upd >= 0 && (cyc - last_upd) < min_gap) min_gap = cyc - last_upd;
      last_upd = cyc;
      n_upd++;
    end
    cadence_in = cin;
  endtask

  task automatic run(input int period, input int high, input int n);
    for (int i = 0; i < n; i++) step((i % period) < high);
  endtask

  task automatic tdrv(input logic [11:0] v);
    bus.torque     = v;
    bus.torque_vld = 1'b1;
    step(1'b0);
    bus.torque_vld = 1'b0;
  endtask

  task automatic release_rst();
    rst       = 1'b0;
    rel_cyc   = cyc;
    first_upd = -1;
    last_upd  = -1;
    min_gap   = 1000000;
  endtask

  initial begin
    bus.torque     = '0;
    bus.torque_vld = 1'b0;

    repeat (3) step(1'b0);
    chk("rst_avg", bus.avg_torque, 16'h0);
    chk("rst_cad", bus.cadence, 16'h0);
    chk("rst_np", bus.not_pedaling, 16'h1);
    chk("rst_upd", bus.cad_upd, 16'h0);
    release_rst();

    tdrv(12'h800);
    chk("avg_seed", bus.avg_torque, 16'h800);
    acc = 16'h8000;
    tdrv(12'h900);
    chk("avg_second", bus.avg_torque, 16'h810);
    acc = acc - (acc >> 4) + 16'h0900;
    for (int i = 0; i < 16; i++) begin
      prev = acc[15:4];
      tdrv(12'h900);
      acc = acc - (acc >> 4) + 16'h0900;
      chk("avg_step", bus.avg_torque, acc[15:4]);
      chk("avg_mono", (bus.avg_torque >= prev) && (bus.avg_torque <= 12'h900), 16'h1);
    end
    repeat (3) step(1'b0);
    chk("avg_hold", bus.avg_torque, acc[15:4]);

    n0 = n_upd;
    run(32, 8, 3 * 256 + 40);
    chk("first_upd_cyc", first_upd[15:0], 16'd256);
    chk("steady_gap", min_gap[15:0], 16'd256);
    chk("steady_nupd", (n_upd - n0) >= 3, 16'h1);
    chk("steady_cad", bus.cadence, 16'd8);
    chk("steady_np", bus.not_pedaling, 16'h0);

    run(4, 2, 600);
`ifdef CADENCE_FILT_EN
    chk("sat_cad", bus.cadence, 16'd0);
    chk("sat_np", bus.not_pedaling, 16'h1);
`else
    chk("sat_cad", bus.cadence, 16'd31);
    chk("sat_np", bus.not_pedaling, 16'h0);
`endif

    run(256, 16, 600);
    chk("slow_cad", bus.cadence, 16'd1);
    chk("slow_np", bus.not_pedaling, 16'h1);

    run(32, 3, 600);
`ifdef CADENCE_FILT_EN
    chk("glitch_cad", bus.cadence, 16'd0);
    chk("glitch_np", bus.not_pedaling, 16'h1);
`else
    chk("glitch_cad", bus.cadence, 16'd8);
    chk("glitch_np", bus.not_pedaling, 16'h0);
`endif

    run(32, 8, 600);
    j = 600;
    for (int i = 0; i < 300 && ((cyc - rel_cyc) % 256) != 100; i++) begin
      step((j % 32) < 8);
      j++;
    end
    chk("pre_rst_cad", bus.cadence, 16'd8);
    rst = 1'b1;
    step(1'b0);
    chk("mid_rst_cad", bus.cadence, 16'd0);
    chk("mid_rst_np", bus.not_pedaling, 16'h1);
    chk("mid_rst_upd", bus.cad_upd, 16'h0);
    chk("mid_rst_avg", bus.avg_torque, 16'h0);
    step(1'b0);
    release_rst();

    tdrv(12'h100);
    chk("reseed", bus.avg_torque, 16'h100);
    run(32, 8, 600);
    chk("post_rst_first_upd", first_upd[15:0], 16'd256);
    chk("post_rst_gap", min_gap[15:0], 16'd256);
    chk("post_rst_cad", bus.cadence, 16'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
